// File: rtl/led_pattern_gen.sv
// Multi-channel LED driver: per-channel OFF/ON/BLINK/BREATHE with 8-bit PWM and a ms timebase.
// Optional LED_PATTERN_SYNC_EN adds sync_n to phase-align the counters of several instances.
module led_pattern_gen #(
    parameter int unsigned CLK_HZ     = 12_000_000,
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned PERIOD_W   = 16,
    parameter int unsigned PWM_BITS   = 8,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst_n,
`ifdef LED_PATTERN_SYNC_EN
    input  logic                         sync_n,
`endif
    input  logic                         cfg_load,
    input  logic [2*NUM_CH-1:0]          cfg_mode,
    input  logic [PERIOD_W*NUM_CH-1:0]   cfg_half_ms,
    input  logic [PWM_BITS*NUM_CH-1:0]   cfg_bright,
    output logic [NUM_CH-1:0]            led_out,
    output logic                         tick_ms,
    output logic [NUM_CH-1:0]            blink_phase
);

    localparam int unsigned          PRE_N   = CLK_HZ / 1000;
    localparam int unsigned          PRE_W   = (PRE_N > 1) ? $clog2(PRE_N) : 1;
    localparam logic [PRE_W-1:0]     PRE_TC  = PRE_W'(PRE_N - 1);
    localparam logic [PWM_BITS-1:0]  PWM_MAX = '1;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [PRE_W-1:0]                   pre_q, pre_d;
    logic                               tick_q, tick_d;
    logic [PWM_BITS-1:0]                pwm_q, pwm_d;
    mode_e                              mode_q [NUM_CH];
    mode_e                              mode_d [NUM_CH];
    dir_e                               dir_q  [NUM_CH];
    dir_e                               dir_d  [NUM_CH];
    logic [NUM_CH-1:0][PERIOD_W-1:0]    half_q, half_d, ms_q, ms_d, eff_m1;
    logic [NUM_CH-1:0][PWM_BITS-1:0]    bright_q, bright_d, level_q, level_d, duty;
    logic [NUM_CH-1:0]                  phase_q, phase_d, led_q, led_d, step, lit;
    logic                               sync_clr;

`ifdef LED_PATTERN_SYNC_EN
    assign sync_clr = ~sync_n;
`else
    assign sync_clr = 1'b0;
`endif

    always_comb begin
        pre_d    = (pre_q == PRE_TC) ? '0 : pre_q + 1'b1;
        tick_d   = (pre_q == PRE_TC);
        pwm_d    = pwm_q + 1'b1;
        mode_d   = mode_q;
        dir_d    = dir_q;
        half_d   = half_q;
        bright_d = bright_q;
        ms_d     = ms_q;
        level_d  = level_q;
        phase_d  = phase_q;
        eff_m1   = '0;
        step     = '0;
        duty     = '0;
        lit      = '0;
        led_d    = '0;

        if (sync_clr) begin
            pre_d  = '0;
            tick_d = 1'b0;
            pwm_d  = '0;
        end

        for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
            // A half-period of 0 behaves as 1 ms.
            eff_m1[ch] = (half_q[ch] == '0) ? '0 : half_q[ch] - 1'b1;
            step[ch]   = tick_q && (ms_q[ch] == eff_m1[ch]);

            case (mode_q[ch])
                MODE_BLINK, MODE_BREATHE: begin
                    if (tick_q) begin
                        ms_d[ch] = step[ch] ? '0 : ms_q[ch] + 1'b1;
                    end
                end
                default: ms_d[ch] = '0;
            endcase

            phase_d[ch] = (mode_q[ch] == MODE_BLINK) ? (phase_q[ch] ^ step[ch]) : 1'b0;

            if ((mode_q[ch] == MODE_BREATHE) && step[ch]) begin
                if (dir_q[ch] == DIR_UP) begin
                    if (level_q[ch] == PWM_MAX) dir_d[ch] = DIR_DOWN;
                    else                        level_d[ch] = level_q[ch] + 1'b1;
                end else begin
                    if (level_q[ch] == '0) dir_d[ch] = DIR_UP;
                    else                   level_d[ch] = level_q[ch] - 1'b1;
                end
            end

            if (cfg_load) begin
                mode_d[ch]   = mode_e'(cfg_mode[2*ch +: 2]);
                half_d[ch]   = cfg_half_ms[PERIOD_W*ch +: PERIOD_W];
                bright_d[ch] = cfg_bright[PWM_BITS*ch +: PWM_BITS];
                ms_d[ch]     = '0;
                phase_d[ch]  = 1'b0;
                level_d[ch]  = '0;
                dir_d[ch]    = DIR_UP;
            end

            if (sync_clr) begin
                ms_d[ch]    = '0;
                phase_d[ch] = 1'b0;
                level_d[ch] = '0;
                dir_d[ch]   = DIR_UP;
            end

            case (mode_q[ch])
                MODE_ON:      duty[ch] = bright_q[ch];
                MODE_BLINK:   duty[ch] = phase_q[ch] ? bright_q[ch] : '0;
                MODE_BREATHE: duty[ch] = level_q[ch];
                default:      duty[ch] = '0;
            endcase

            // Full-scale duty is forced lit so there is no one-cycle gap at pwm wrap.
            lit[ch]   = (duty[ch] == PWM_MAX) || (pwm_q < duty[ch]);
            led_d[ch] = lit[ch] ^ ACTIVE_LOW;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q    <= '0;
            tick_q   <= 1'b0;
            pwm_q    <= '0;
            half_q   <= '0;
            bright_q <= '0;
            ms_q     <= '0;
            level_q  <= '0;
            phase_q  <= '0;
            led_q    <= {NUM_CH{ACTIVE_LOW}};
            for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
                mode_q[ch] <= MODE_OFF;
                dir_q[ch]  <= DIR_UP;
            end
        end else begin
            pre_q    <= pre_d;
            tick_q   <= tick_d;
            pwm_q    <= pwm_d;
            half_q   <= half_d;
            bright_q <= bright_d;
            ms_q     <= ms_d;
            level_q  <= level_d;
            phase_q  <= phase_d;
            led_q    <= led_d;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
        end
    end

    assign led_out     = led_q;
    assign tick_ms     = tick_q;
    assign blink_phase = phase_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomized self-checking bench for led_pattern_gen; reference model works in elapsed ms ticks.
module tb_led_pattern_gen;

    localparam int unsigned NCH = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_load = 1'b0;
    logic [5:0]    cfg_mode = '0;
    logic [47:0]   cfg_half_ms = '0;
    logic [23:0]   cfg_bright = '0;
    logic [2:0]    led_out;
    logic          tick_ms;
    logic [2:0]    blink_phase;
`ifdef LED_PATTERN_SYNC_EN
    logic          sync_n = 1'b1;
`endif

    always #5 clk = ~clk;

    led_pattern_gen #(
        .CLK_HZ    (8000),
        .NUM_CH    (3),
        .PERIOD_W  (16),
        .PWM_BITS  (8),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef LED_PATTERN_SYNC_EN
        .sync_n     (sync_n),
`endif
        .cfg_load   (cfg_load),
        .cfg_mode   (cfg_mode),
        .cfg_half_ms(cfg_half_ms),
        .cfg_bright (cfg_bright),
        .led_out    (led_out),
        .tick_ms    (tick_ms),
        .blink_phase(blink_phase)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: edges since reset, and ms ticks counted since the last load.
    int unsigned n;
    int unsigned m_mode   [NCH];
    int unsigned m_half   [NCH];
    int unsigned m_bright [NCH];
    int unsigned m_t      [NCH];
    logic [2:0]  e_led, e_phase;
    logic        e_tick;

    function automatic int unsigned eff(input int unsigned c);
        return (m_half[c] == 0) ? 1 : m_half[c];
    endfunction

    function automatic int unsigned breathe_level(input int unsigned s);
        int unsigned p;
        p = s % 512;
        return (p < 256) ? p : 511 - p;
    endfunction

    function automatic int unsigned duty_of(input int unsigned c);
        int unsigned s;
        s = m_t[c] / eff(c);
        case (m_mode[c])
            0:       return 0;
            1:       return m_bright[c];
            2:       return (s % 2 == 1) ? m_bright[c] : 0;
            default: return breathe_level(s);
        endcase
    endfunction

    task automatic model_reset();
        n = 0;
        for (int c = 0; c < NCH; c++) begin
            m_mode[c] = 0; m_half[c] = 0; m_bright[c] = 0; m_t[c] = 0;
        end
        e_led = 3'b111; e_phase = '0; e_tick = 1'b0;
    endtask

    task automatic step_cycle();
        logic [2:0]  new_led;
        bit          tick_prev;
        int unsigned d;
        @(posedge clk);
        tick_prev = (n > 0) && (n % 8 == 0);
        for (int c = 0; c < NCH; c++) begin
            d = duty_of(c);
            new_led[c] = !((d == 255) || ((n % 256) < d));
        end
        for (int c = 0; c < NCH; c++) begin
            if (cfg_load) begin
                m_mode[c]   = cfg_mode[2*c +: 2];
                m_half[c]   = cfg_half_ms[16*c +: 16];
                m_bright[c] = cfg_bright[8*c +: 8];
                m_t[c]      = 0;
            end else if (tick_prev && m_mode[c] >= 2) begin
                m_t[c]++;
            end
        end
        n++;
        e_tick = (n % 8 == 0);
        e_led  = new_led;
        for (int c = 0; c < NCH; c++)
            e_phase[c] = (m_mode[c] == 2) ? ((m_t[c] / eff(c)) % 2 == 1) : 1'b0;
        @(negedge clk);
        check_eq("tick_ms", {31'b0, tick_ms}, {31'b0, e_tick});
        check_eq("led_out", {29'b0, led_out}, {29'b0, e_led});
        check_eq("blink_phase", {29'b0, blink_phase}, {29'b0, e_phase});
    endtask

    task automatic run(input int unsigned cycles);
        repeat (cycles) step_cycle();
    endtask

    task automatic do_load(input logic [5:0] m, input logic [47:0] h, input logic [23:0] b);
        cfg_mode = m; cfg_half_ms = h; cfg_bright = b;
        cfg_load = 1'b1;
        step_cycle();
        cfg_load = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned cnt;
        int unsigned guard;
        logic [5:0]  rm;
        logic [47:0] rh;
        logic [23:0] rb;

        model_reset();
        repeat (5) begin
            @(negedge clk);
            check_eq("rst_led", {29'b0, led_out}, 32'h7);
            check_eq("rst_tick", {31'b0, tick_ms}, 32'h0);
            check_eq("rst_phase", {29'b0, blink_phase}, 32'h0);
        end
        rst_n = 1'b1;
        run(40);

        // ON: ch0 full, ch1 at 64/256, ch2 off
        do_load(6'b00_01_01, 48'h0000_0000_0000, 24'h00_40_FF);
        cnt = 0;
        repeat (256) begin
            step_cycle();
            if (led_out[1] == 1'b0) cnt++;
        end
        check_eq("on_ch1_lit_cycles", cnt, 32'd64);
        run(100);

        // BLINK half 3, then half 0
        do_load(6'b00_00_10, 48'h0000_0000_0003, 24'h00_00_FF);
        run(200);
        do_load(6'b00_00_10, 48'h0000_0000_0000, 24'h00_00_FF);
        run(100);

        // Reload landing on a tick, mid-half-period
        do_load(6'b00_00_10, 48'h0000_0000_0003, 24'h00_00_FF);
        guard = 0;
        while (!(e_tick && (m_t[0] % 3 == 1)) && guard < 200) begin
            step_cycle();
            guard++;
        end
        check_eq("collision_setup", {31'b0, guard < 200}, 32'h1);
        do_load(6'b00_00_10, 48'h0000_0000_0003, 24'h00_00_FF);
        check_eq("collision_phase", {31'b0, blink_phase[0]}, 32'h0);
        cnt = 0;
        while (blink_phase[0] == 1'b0 && cnt < 100) begin
            step_cycle();
            cnt++;
        end
        check_eq("collision_next_toggle", cnt, 32'd24);

        // BREATHE half 1 over a full triangle
        do_load(6'b00_00_11, 48'h0000_0000_0001, 24'h00_00_00);
        run(4400);

        // Randomized configurations
        for (int it = 0; it < 12; it++) begin
            rm = 6'($urandom);
            for (int c = 0; c < NCH; c++) begin
                rh[16*c +: 16] = ($urandom_range(0, 9) == 9) ? 16'($urandom_range(1000, 65535))
                                                              : 16'($urandom_range(0, 4));
                case ($urandom_range(0, 4))
                    0:       rb[8*c +: 8] = 8'h00;
                    1:       rb[8*c +: 8] = 8'hFF;
                    default: rb[8*c +: 8] = 8'($urandom);
                endcase
            end
            do_load(rm, rh, rb);
            run($urandom_range(200, 1500));
        end

        // Async reset mid-breathe at level 100 while ch0 is lit
        do_load(6'b00_00_11, 48'h0000_0000_0001, 24'h00_00_00);
        guard = 0;
        while (!(duty_of(0) == 100 && e_led[0] == 1'b0) && guard < 2000) begin
            step_cycle();
            guard++;
        end
        check_eq("breathe_reach_100", {31'b0, guard < 2000}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_led", {29'b0, led_out}, 32'h7);
        check_eq("async_rst_phase", {29'b0, blink_phase}, 32'h0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run(600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised multi-channel LED driver. Successor to the fixed single-rate blinker on the iCESugar UP5K board.
- Per channel: mode (off / steady / blink / breathe), blink half-period in milliseconds, and 8-bit PWM brightness.
- Sits between board-level control logic and the RGB LED pins; drives the pins directly, polarity set by parameter.

Parameters:
- CLK_HZ, 12_000_000, input clock frequency; ms prescaler terminal count = CLK_HZ/1000 - 1.
- NUM_CH, 3, number of LED channels.
- PERIOD_W, 16, width of per-channel half-period field (ms).
- PWM_BITS, 8, brightness / PWM resolution.
- ACTIVE_LOW, 1, 1 = pin low means LED lit.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_load  in  1  single-cycle strobe; latches all cfg_* inputs.
- cfg_mode  in  2*NUM_CH  per-channel mode, channel i at bits [2i+1:2i]; 00 OFF, 01 ON, 10 BLINK, 11 BREATHE.
- cfg_half_ms  in  PERIOD_W*NUM_CH  per-channel half-period / breathe step interval in ms.
- cfg_bright  in  PWM_BITS*NUM_CH  per-channel duty for ON/BLINK.
- led_out  out  NUM_CH  LED pins, polarity per ACTIVE_LOW.
- tick_ms  out  1  one-cycle pulse per elapsed millisecond.
- blink_phase  out  NUM_CH  current blink phase per channel (1 = lit half).

Behaviour:
- Reset (async assert, sync release):
  - All latched modes = OFF; prescaler, ms counters, PWM counter, breathe levels = 0; breathe direction = up; blink_phase = 0; tick_ms = 0.
  - led_out = all inactive (all 1s when ACTIVE_LOW=1).
- Prescaler:
  - Counts 0..CLK_HZ/1000-1, then wraps to 0.
  - tick_ms is registered high for exactly the cycle the counter wraps.
  - Free-running; cfg_load does not reset it.
- PWM counter:
  - PWM_BITS wide, increments every clk, wraps from 2^PWM_BITS-1 to 0.
  - Channel lit when pwm_cnt < duty.
  - duty = all ones forces constant lit (no 1-cycle gap); duty = 0 means never lit.
- Per-channel duty by mode:
  - OFF: 0.
  - ON: latched bright.
  - BLINK: latched bright when blink_phase=1, else 0.
  - BREATHE: breathe level.
- Per-channel ms counter:
  - Advances on tick_ms.
  - On reaching eff_half-1 (eff_half = max(latched half_ms, 1)) with tick_ms: clears to 0 and fires a step event.
- BLINK: step event toggles blink_phase. Full on+off cycle = 2*eff_half ms.
- BREATHE: step event moves level ±1.
  - Up: at 2^PWM_BITS-1, direction flips to down and level holds for that step.
  - Down: at 0, direction flips to up and level holds.
  - Triangle period = 2*(2^PWM_BITS)*eff_half ms.
- OFF/ON: ms counter and blink_phase held at 0.
- cfg_load (registered, takes effect next cycle), applied to every channel:
  - Latch mode, half_ms, and bright.
  - Clear ms counter, blink_phase, and breathe level; direction = up.
  - Same behaviour whether the channel was mid-period or not.
  - cfg_load coincident with tick_ms: load wins; no step that cycle.
- Output latency: led_out registered, 1 cycle after the pwm_cnt/duty compare.
- Width rule: compares are unsigned at full width; no truncation of cfg_half_ms.
- Reset asserted mid-operation: outputs inactive immediately, without waiting for a clock edge.

Optional Feature:
LED_PATTERN_SYNC_EN
- Defined:
  - Adds input port sync_n (1 bit, active-low, synchronous, sampled on clk).
  - While low: prescaler, all ms counters, PWM counter, blink_phase, and breathe levels cleared; direction = up.
  - Latched config kept.
  - Allows multiple boards/instances to phase-align blinking.
- Undefined: port absent; behaviour exactly as above.

Test Plan:
All scenarios use CLK_HZ=8000 (8 clk per ms), NUM_CH=3, PWM_BITS=8.
- Reset: hold rst_n low 5 cycles, then release -> led_out=3'b111 (inactive), tick_ms first pulses at cycle 8 after release, then every 8 cycles.
- ON: cfg_load with ch0 ON, bright=255 -> led_out[0]=0 continuously. ch1 ON, bright=64 -> led_out[1]=0 for exactly 64 of every 256 cycles. ch2 OFF -> 1 always.
- BLINK: ch0 BLINK, half_ms=3, bright=255 -> blink_phase[0] toggles every 24 cycles; led_out[0] follows 1 cycle later. half_ms=0 -> toggles every 8 cycles.
- BREATHE: ch0 BREATHE, half_ms=1 -> level rises 0→255 over 255 ms, holds 1 step, falls to 0, repeats. Period = 512 ms.
- Reconfig collision: BLINK running mid-half-period, cfg_load asserted in the same cycle as tick_ms -> ms counter=0, phase=0, no extra toggle. Next toggle occurs a full eff_half later.
- Reset mid-breathe at level 100 -> led_out inactive immediately (asynchronous); after release, level restarts at 0 and mode = OFF.
- With LED_PATTERN_SYNC_EN: two instances with offset phase; pulse sync_n low 1 cycle -> identical led_out thereafter.
